mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Load/store unit in the MEM stage; consumes the EX/MEM outputs of the execute stage (mem_op, ALU-computed address, rs2 store data).
- Issues one data-memory request per memory instruction over a valid/ready request and valid response handshake.
- Aligns and sign- or zero-extends load data, and generates byte strobes for stores.
- Stalls the pipeline while an access is outstanding; reports misaligned accesses and bus errors as traps.

Parameters:
- XLEN, 64, data/address width.
- STRB_W, XLEN/8, store byte-strobe width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- valid_i  in  1  EX/MEM slot holds a live instruction.
- mem_op_i  in  MEMOP_LEN  access type.
- addr_i  in  XLEN  effective address, i.e. the execute stage's ALU result.
- store_data_i  in  XLEN  rs2 data.
- flush_i  in  1  kill the current instruction.
- dmem_req_valid_o  out  1  request valid.
- dmem_req_ready_i  in  1  request accepted.
- dmem_addr_o  out  XLEN  address, aligned down to 8 bytes.
- dmem_wen_o  out  1  1 = store.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_wstrb_o  out  STRB_W  byte strobes; 0 for loads.
- dmem_resp_valid_i  in  1  response valid.
- dmem_rdata_i  in  XLEN  8-byte-aligned read data.
- dmem_resp_err_i  in  1  bus error, qualified by resp_valid.
- load_data_o  out  XLEN  extended load result.
- load_data_valid_o  out  1  one-cycle pulse with the result.
- mem_stall_o  out  1  hold IF..EX/MEM.
- misalign_o  out  1  one-cycle pulse; load or store address misaligned.
- access_fault_o  out  1  one-cycle pulse; bus error.

Behaviour:
- Reset: state = IDLE; every output 0; captured request registers 0.
- start = valid_i & (mem_op_i != MEMOP_NONE) & ~flush_i & aligned, evaluated in IDLE.
- Alignment rules: byte always aligned; half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
- Misaligned access in IDLE (valid, op != NONE, no flush):
  - misalign_o pulses that cycle.
  - No request is issued, no stall, state stays IDLE.
- IDLE and start:
  - Capture op, addr, wdata and strobes into registers.
  - Go to REQ.
  - mem_stall_o = 1 combinationally in this cycle.
- REQ:
  - dmem_req_valid_o = 1; request fields are stable from the registers.
  - If req_ready is 1, go to WAIT.
  - flush_i before acceptance: return to IDLE with no request; flush has priority over ready in the same cycle.
- WAIT:
  - Stay until resp_valid arrives.
  - On resp_valid with no error:
    - Loads: load_data_valid_o = 1 and load_data_o = extend(rdata >> (addr[2:0]*8)).
    - Stores: no data pulse.
    - Return to IDLE; mem_stall_o = 0 in this cycle so the pipeline advances at the edge.
  - On resp_valid with resp_err: access_fault_o = 1, no data pulse, return to IDLE.
  - flush_i while in WAIT: go to DRAIN.
- DRAIN:
  - Wait for resp_valid, discard the response (no pulses), return to IDLE.
  - mem_stall_o = 1 throughout.
- mem_stall_o = 1 in REQ and DRAIN, in WAIT unless resp_valid, and in IDLE when start is true.
- Minimum latency: 3 cycles, i.e. IDLE → REQ → WAIT with response in the same cycle as arrival in WAIT. The response is never accepted while in REQ.
- Extension:
  - LB/LH/LW: sign-extend from bit 7/15/31.
  - LBU/LHU/LWU: zero-extend.
  - LD: pass through.
- Store strobes:
  - SB: 1<<a.
  - SH: 3<<a.
  - SW: 0xF<<a.
  - SD: 0xFF.
  - Here a = addr[2:0].
- Store data: wdata = byte/half/word replicated across all lanes.
- rst asserted mid-operation: return immediately to IDLE and clear all outputs. An outstanding response arriving after reset is ignored because it arrives in IDLE.

Decomposition:
- Shared package/defines header:
  - MEMOP_LEN.
  - MEMOP_NONE/LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD codes.
  - LSU state encodings (IDLE, REQ, WAIT, DRAIN).
- One combinational sub-module, lsu_align: performs the misalign check, strobe/wdata generation and load extraction/extension; shared by the request and response paths.

Test Plan:
- LW at addr 0x8000_0004, rdata 0x8765_4321_0000_0000, ready immediate, response 1 cycle later → load_data_o = 0xFFFF_FFFF_8765_4321; valid pulses once; stall high for exactly 2 cycles.
- LBU at addr 0x8000_0003, rdata byte3 = 0xF0 → load_data_o = 0x0000_0000_0000_00F0; dmem_addr_o = 0x8000_0000; wstrb = 0.
- SH at addr 0x8000_0006, store_data 0x1234 with req_ready held low 3 cycles → req_valid is held stable; wstrb = 0xC0; wdata = 0x1234 replicated; no load_data_valid pulse.
- LD at addr 0x8000_0004 → misalign_o pulses 1 cycle; dmem_req_valid_o is never asserted; stall stays 0.
- LW accepted, then flush_i asserted in WAIT, response arrives 4 cycles later → goes to DRAIN; no pulses; stall deasserts only in the cycle after the response.
- LW whose response has resp_err = 1 → access_fault_o pulses; load_data_valid_o = 0. Also apply rst mid-WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared memory-op codes, LSU state encodings and op decode helpers for the MEM-stage LSU.
package mem_lsu_pkg;

    localparam int unsigned MEMOP_LEN = 4;

    localparam logic [MEMOP_LEN-1:0] MEMOP_NONE = 4'd0;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LB   = 4'd1;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LH   = 4'd2;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LW   = 4'd3;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LD   = 4'd4;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LBU  = 4'd5;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LHU  = 4'd6;
    localparam logic [MEMOP_LEN-1:0] MEMOP_LWU  = 4'd7;
    localparam logic [MEMOP_LEN-1:0] MEMOP_SB   = 4'd8;
    localparam logic [MEMOP_LEN-1:0] MEMOP_SH   = 4'd9;
    localparam logic [MEMOP_LEN-1:0] MEMOP_SW   = 4'd10;
    localparam logic [MEMOP_LEN-1:0] MEMOP_SD   = 4'd11;

    localparam logic [1:0] LSU_IDLE  = 2'd0;
    localparam logic [1:0] LSU_REQ   = 2'd1;
    localparam logic [1:0] LSU_WAIT  = 2'd2;
    localparam logic [1:0] LSU_DRAIN = 2'd3;

    // log2 of the access size in bytes
    function automatic logic [1:0] memop_size(input logic [MEMOP_LEN-1:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: memop_size = 2'd0;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: memop_size = 2'd1;
            MEMOP_LW, MEMOP_LWU, MEMOP_SW: memop_size = 2'd2;
            default:                       memop_size = 2'd3;
        endcase
    endfunction

    function automatic logic memop_is_store(input logic [MEMOP_LEN-1:0] op);
        memop_is_store = (op == MEMOP_SB) || (op == MEMOP_SH) ||
                         (op == MEMOP_SW) || (op == MEMOP_SD);
    endfunction

    function automatic logic memop_is_unsigned(input logic [MEMOP_LEN-1:0] op);
        memop_is_unsigned = (op == MEMOP_LBU) || (op == MEMOP_LHU) || (op == MEMOP_LWU);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational alignment helper: misalign check, store strobes/lane replication,
// and load byte extraction with sign/zero extension.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STRB_W = XLEN / 8
) (
    input  logic [MEMOP_LEN-1:0] op_i,
    input  logic [2:0]           offs_i,
    input  logic [XLEN-1:0]      store_data_i,
    input  logic [XLEN-1:0]      rdata_i,
    output logic                 misalign_o,
    output logic [STRB_W-1:0]    wstrb_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic [XLEN-1:0]      load_data_o
);

    logic [XLEN-1:0] shifted;
    logic            is_uns;

    always_comb begin
        shifted     = rdata_i >> {offs_i, 3'b000};
        is_uns      = memop_is_unsigned(op_i);
        misalign_o  = 1'b0;
        wstrb_o     = '0;
        wdata_o     = store_data_i;
        load_data_o = shifted;
        case (memop_size(op_i))
            2'd0: begin
                wstrb_o     = STRB_W'(1) << offs_i;
                wdata_o     = {(XLEN/8){store_data_i[7:0]}};
                load_data_o = is_uns ? XLEN'(shifted[7:0])
                                     : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                misalign_o  = offs_i[0];
                wstrb_o     = STRB_W'(3) << offs_i;
                wdata_o     = {(XLEN/16){store_data_i[15:0]}};
                load_data_o = is_uns ? XLEN'(shifted[15:0])
                                     : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            2'd2: begin
                misalign_o  = |offs_i[1:0];
                wstrb_o     = STRB_W'(15) << offs_i;
                wdata_o     = {(XLEN/32){store_data_i[31:0]}};
                load_data_o = is_uns ? XLEN'(shifted[31:0])
                                     : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            end
            default: begin
                misalign_o = |offs_i;
                wstrb_o    = '1;
            end
        endcase
        if (!memop_is_store(op_i)) wstrb_o = '0;
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one data-memory access per instruction over a
// valid/ready request and valid response, with stall, misalign and fault reporting.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STRB_W = XLEN / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [MEMOP_LEN-1:0] mem_op_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      store_data_i,
    input  logic                 flush_i,
    output logic                 dmem_req_valid_o,
    input  logic                 dmem_req_ready_i,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic                 dmem_wen_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    output logic [STRB_W-1:0]    dmem_wstrb_o,
    input  logic                 dmem_resp_valid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    input  logic                 dmem_resp_err_i,
    output logic [XLEN-1:0]      load_data_o,
    output logic                 load_data_valid_o,
    output logic                 mem_stall_o,
    output logic                 misalign_o,
    output logic                 access_fault_o
);

    logic [1:0]           state_q, state_d;
    logic [MEMOP_LEN-1:0] op_q, op_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic                 wen_q, wen_d;

    logic                 is_idle_c;
    logic [MEMOP_LEN-1:0] al_op_c;
    logic [2:0]           al_offs_c;
    logic                 al_misalign;
    logic [STRB_W-1:0]    al_wstrb;
    logic [XLEN-1:0]      al_wdata;
    logic [XLEN-1:0]      al_load;

    logic live_c, start_c, stall_c, ld_valid_c, fault_c, mis_c;

    // The aligner sees the live instruction in IDLE and the captured request afterwards.
    assign is_idle_c = (state_q == LSU_IDLE);
    assign al_op_c   = is_idle_c ? mem_op_i : op_q;
    assign al_offs_c = is_idle_c ? addr_i[2:0] : addr_q[2:0];

    lsu_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
        .op_i         (al_op_c),
        .offs_i       (al_offs_c),
        .store_data_i (store_data_i),
        .rdata_i      (dmem_rdata_i),
        .misalign_o   (al_misalign),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wen_d      = wen_q;
        live_c     = valid_i && (mem_op_i != MEMOP_NONE) && !flush_i;
        start_c    = 1'b0;
        stall_c    = 1'b0;
        ld_valid_c = 1'b0;
        fault_c    = 1'b0;
        mis_c      = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                start_c = live_c && !al_misalign;
                mis_c   = live_c && al_misalign;
                stall_c = start_c;
                if (start_c) begin
                    op_d    = mem_op_i;
                    addr_d  = addr_i;
                    wdata_d = al_wdata;
                    wstrb_d = al_wstrb;
                    wen_d   = memop_is_store(mem_op_i);
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                stall_c = 1'b1;
                if (flush_i)               state_d = LSU_IDLE;
                else if (dmem_req_ready_i) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                stall_c = !dmem_resp_valid_i;
                // A response landing with a flush is consumed but its result is dropped.
                if (dmem_resp_valid_i) begin
                    state_d = LSU_IDLE;
                    if (!flush_i) begin
                        fault_c    = dmem_resp_err_i;
                        ld_valid_c = !dmem_resp_err_i && !wen_q;
                    end
                end else if (flush_i) begin
                    state_d = LSU_DRAIN;
                end
            end
            default: begin
                stall_c = 1'b1;
                if (dmem_resp_valid_i) state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            op_q    <= MEMOP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wen_q   <= wen_d;
        end
    end

    assign dmem_req_valid_o = (state_q == LSU_REQ);
    assign dmem_addr_o      = {addr_q[XLEN-1:3], 3'b000};
    assign dmem_wen_o       = wen_q;
    assign dmem_wdata_o     = wdata_q;
    assign dmem_wstrb_o     = wstrb_q;

    // Same-cycle status is forced low while reset is held.
    assign mem_stall_o       = stall_c && !rst;
    assign misalign_o        = mis_c && !rst;
    assign access_fault_o    = fault_c && !rst;
    assign load_data_valid_o = ld_valid_c && !rst;
    assign load_data_o       = (ld_valid_c && !rst) ? al_load : '0;

endmodule
